// File: rtl/cache_pkg.sv
// Shared types and constants for the cache fill arbiter and its word counters.
package cache_pkg;

    localparam int BLOCK_WORDS_DEF = 8;
    localparam int WORD_BYTES      = 2;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FILL_D = 2'd1;
    localparam logic [1:0] ST_FILL_I = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        FILL_D = ST_FILL_D,
        FILL_I = ST_FILL_I,
        DONE   = ST_DONE
    } fill_state_t;

endpackage

// File: rtl/fill_word_counter.sv
// Word counter for one block fill: clear, increment, terminal count at BLOCK_WORDS.
module fill_word_counter
    import cache_pkg::*;
#(
    parameter int BLOCK_WORDS = BLOCK_WORDS_DEF,
    parameter int CNT_W       = $clog2(BLOCK_WORDS) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc  = (cnt_q == CNT_W'(BLOCK_WORDS));
    assign cnt = cnt_q;

    // Saturates at the terminal count so surplus increments are harmless.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !tc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cache_fill_arbiter.sv
// Arbitrates the shared memory read port between I-cache and D-cache block fills.
// Optional FILL_STARVE_GUARD_EN: an I miss passed over once wins the next arbitration.
module cache_fill_arbiter
    import cache_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int BLOCK_WORDS = BLOCK_WORDS_DEF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           icache_miss,
    input  logic [ADDR_W-1:0]              icache_addr,
    input  logic                           dcache_miss,
    input  logic [ADDR_W-1:0]              dcache_addr,
    input  logic                           mem_data_valid,
    output logic                           mem_en,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic [$clog2(BLOCK_WORDS)-1:0] fill_word_idx,
    output logic                           icache_fill_we,
    output logic                           dcache_fill_we,
    output logic                           icache_tag_we,
    output logic                           dcache_tag_we,
    output logic                           busy
);

    localparam int IDX_W = $clog2(BLOCK_WORDS);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(WORD_BYTES * BLOCK_WORDS - 1);

    fill_state_t       state_q, state_d;
    logic              owner_q, owner_d;
    logic [ADDR_W-1:0] base_q, base_d;

    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  rx_cnt;
    logic              issue_tc;
    logic              rx_tc;
    logic              cnt_clr;
    logic              filling;
    logic              rx_take;
    logic              rx_last;
    logic              i_first;
    logic              gnt_d;
    logic              gnt_i;

    assign filling = (state_q == FILL_D) || (state_q == FILL_I);
    assign cnt_clr = (state_q == IDLE) || (state_q == DONE);
    assign rx_take = filling && mem_data_valid && !rx_tc;
    assign rx_last = (rx_cnt == CNT_W'(BLOCK_WORDS - 1));

    assign gnt_d = (state_q == IDLE) && dcache_miss && !(i_first && icache_miss);
    assign gnt_i = (state_q == IDLE) && icache_miss && !gnt_d;

`ifdef FILL_STARVE_GUARD_EN
    logic i_waited_q, i_waited_d;

    assign i_first = i_waited_q;

    always_comb begin
        i_waited_d = i_waited_q;
        if (gnt_i) begin
            i_waited_d = 1'b0;
        end else if (gnt_d && icache_miss) begin
            i_waited_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_waited_q <= 1'b0;
        end else begin
            i_waited_q <= i_waited_d;
        end
    end
`else
    assign i_first = 1'b0;
`endif

    fill_word_counter #(
        .BLOCK_WORDS (BLOCK_WORDS),
        .CNT_W       (CNT_W)
    ) u_issue_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (mem_en),
        .cnt   (issue_cnt),
        .tc    (issue_tc)
    );

    fill_word_counter #(
        .BLOCK_WORDS (BLOCK_WORDS),
        .CNT_W       (CNT_W)
    ) u_rx_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (rx_take),
        .cnt   (rx_cnt),
        .tc    (rx_tc)
    );

    // Block base is aligned, so the word offset never carries out of the block.
    assign mem_en   = filling && !issue_tc;
    assign mem_addr = mem_en ?
                      (base_q + (ADDR_W'(issue_cnt[IDX_W-1:0]) << $clog2(WORD_BYTES))) :
                      '0;

    assign icache_fill_we = rx_take && (owner_q == OWNER_I);
    assign dcache_fill_we = rx_take && (owner_q == OWNER_D);
    assign fill_word_idx  = rx_take ? rx_cnt[IDX_W-1:0] : '0;
    assign icache_tag_we  = (state_q == DONE) && (owner_q == OWNER_I);
    assign dcache_tag_we  = (state_q == DONE) && (owner_q == OWNER_D);
    assign busy           = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        base_d  = base_q;
        case (state_q)
            IDLE: begin
                if (gnt_d) begin
                    state_d = FILL_D;
                    owner_d = OWNER_D;
                    base_d  = dcache_addr & ALIGN_MASK;
                end else if (gnt_i) begin
                    state_d = FILL_I;
                    owner_d = OWNER_I;
                    base_d  = icache_addr & ALIGN_MASK;
                end
            end
            FILL_D, FILL_I: begin
                if (rx_take && rx_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= OWNER_I;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            base_q  <= base_d;
        end
    end

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed bench for cache_fill_arbiter with a fixed-latency memory model.
module tb_cache_fill_arbiter;

    localparam int AW  = 16;
    localparam int BW  = 8;
    localparam int LAT = 4;
    localparam int NLOG = 4096;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          icache_miss = 1'b0;
    logic [AW-1:0] icache_addr = '0;
    logic          dcache_miss = 1'b0;
    logic [AW-1:0] dcache_addr = '0;
    logic          mem_data_valid = 1'b0;
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [2:0]    fill_word_idx;
    logic          icache_fill_we;
    logic          dcache_fill_we;
    logic          icache_tag_we;
    logic          dcache_tag_we;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit auto_mem = 1'b1;
    bit man_valid [0:NLOG-1];

    logic          log_en   [0:NLOG-1];
    logic [AW-1:0] log_addr [0:NLOG-1];
    logic [2:0]    log_idx  [0:NLOG-1];
    logic          log_ifw  [0:NLOG-1];
    logic          log_dfw  [0:NLOG-1];
    logic          log_itw  [0:NLOG-1];
    logic          log_dtw  [0:NLOG-1];
    logic          log_busy [0:NLOG-1];

    cache_fill_arbiter #(.ADDR_W(AW), .BLOCK_WORDS(BW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .icache_miss    (icache_miss),
        .icache_addr    (icache_addr),
        .dcache_miss    (dcache_miss),
        .dcache_addr    (dcache_addr),
        .mem_data_valid (mem_data_valid),
        .mem_en         (mem_en),
        .mem_addr       (mem_addr),
        .fill_word_idx  (fill_word_idx),
        .icache_fill_we (icache_fill_we),
        .dcache_fill_we (dcache_fill_we),
        .icache_tag_we  (icache_tag_we),
        .dcache_tag_we  (dcache_tag_we),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    // Samples the current cycle at the falling edge, then advances to just after the next rising edge.
    task automatic step();
        @(negedge clk);
        log_en[cyc]   = mem_en;
        log_addr[cyc] = mem_addr;
        log_idx[cyc]  = fill_word_idx;
        log_ifw[cyc]  = icache_fill_we;
        log_dfw[cyc]  = dcache_fill_we;
        log_itw[cyc]  = icache_tag_we;
        log_dtw[cyc]  = dcache_tag_we;
        log_busy[cyc] = busy;
        @(posedge clk);
        #1;
        cyc++;
        if (log_dtw[cyc-1]) dcache_miss = 1'b0;
        if (log_itw[cyc-1]) icache_miss = 1'b0;
        if (auto_mem) mem_data_valid = (cyc >= LAT) ? log_en[cyc-LAT] : 1'b0;
        else          mem_data_valid = man_valid[cyc];
    endtask

    function automatic logic [24:0] obs(int t);
        return {log_en[t], log_addr[t], log_ifw[t], log_dfw[t], log_idx[t],
                log_itw[t], log_dtw[t], log_busy[t]};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({mem_en, mem_addr, fill_word_idx, icache_fill_we, dcache_fill_we,
             icache_tag_we, dcache_tag_we, busy} !== 25'h0)
            begin errors++; $display("FAIL reset_outputs: got %h required 0",
                {mem_en, mem_addr, fill_word_idx, icache_fill_we, dcache_fill_we,
                 icache_tag_we, dcache_tag_we, busy}); end
        mem_data_valid = 1'b1;
        #1;
        checks++;
        if ({icache_fill_we, dcache_fill_we} !== 2'b00)
            begin errors++; $display("FAIL reset_valid_ignored: got %b required 00",
                {icache_fill_we, dcache_fill_we}); end
        mem_data_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) step();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs(k) !== 25'h0)
                begin errors++; $display("FAIL reset_idle cyc %0d: got %h required 0", k, obs(k)); end
        end
    endtask

    task automatic test_single_d();
        int t0;
        logic e_en, e_dfw, e_dtw, e_busy;
        logic [AW-1:0] e_addr;
        logic [2:0] e_idx;
        t0 = cyc;
        dcache_addr = 16'h1236;
        dcache_miss = 1'b1;
        repeat (16) step();
        for (int k = 0; k < 16; k++) begin
            e_en   = (k >= 1 && k <= 8);
            e_addr = e_en ? 16'h1230 + 16'(2*(k-1)) : 16'h0;
            e_dfw  = (k >= 5 && k <= 12);
            e_idx  = e_dfw ? 3'(k-5) : 3'd0;
            e_dtw  = (k == 13);
            e_busy = (k >= 1 && k <= 13);
            checks++;
            if (obs(t0+k) !== {e_en, e_addr, 1'b0, e_dfw, e_idx, 1'b0, e_dtw, e_busy})
                begin errors++; $display("FAIL single_d cyc %0d: got %h required %h (en,addr,ifw,dfw,idx,itw,dtw,busy)",
                    k, obs(t0+k), {e_en, e_addr, 1'b0, e_dfw, e_idx, 1'b0, e_dtw, e_busy}); end
        end
    endtask

    task automatic test_simultaneous();
        int t0, dk, ik;
        logic e_en, e_dfw, e_ifw, e_dtw, e_itw, e_busy;
        logic [AW-1:0] e_addr;
        logic [2:0] e_idx;
        t0 = cyc;
        icache_addr = 16'h0040;
        dcache_addr = 16'h8000;
        icache_miss = 1'b1;
        dcache_miss = 1'b1;
        repeat (30) step();
        for (int k = 0; k < 30; k++) begin
            dk = k;
            ik = k - 14;
            e_en   = (dk >= 1 && dk <= 8) || (ik >= 1 && ik <= 8);
            e_addr = (dk >= 1 && dk <= 8) ? 16'h8000 + 16'(2*(dk-1)) :
                     (ik >= 1 && ik <= 8) ? 16'h0040 + 16'(2*(ik-1)) : 16'h0;
            e_dfw  = (dk >= 5 && dk <= 12);
            e_ifw  = (ik >= 5 && ik <= 12);
            e_idx  = e_dfw ? 3'(dk-5) : (e_ifw ? 3'(ik-5) : 3'd0);
            e_dtw  = (dk == 13);
            e_itw  = (ik == 13);
            e_busy = (dk >= 1 && dk <= 13) || (ik >= 1 && ik <= 13);
            checks++;
            if (obs(t0+k) !== {e_en, e_addr, e_ifw, e_dfw, e_idx, e_itw, e_dtw, e_busy})
                begin errors++; $display("FAIL simultaneous cyc %0d: got %h required %h (en,addr,ifw,dfw,idx,itw,dtw,busy)",
                    k, obs(t0+k), {e_en, e_addr, e_ifw, e_dfw, e_idx, e_itw, e_dtw, e_busy}); end
            checks++;
            if ((log_ifw[t0+k] && log_dfw[t0+k]) || (log_itw[t0+k] && log_dtw[t0+k]))
                begin errors++; $display("FAIL exclusive_we cyc %0d: got ifw=%b dfw=%b itw=%b dtw=%b required no pair",
                    k, log_ifw[t0+k], log_dfw[t0+k], log_itw[t0+k], log_dtw[t0+k]); end
        end
    endtask

    task automatic test_irregular();
        int t0, n;
        int offs [10] = '{5, 7, 8, 11, 12, 14, 15, 17, 18, 19};
        logic e_en, e_dfw, e_dtw, e_busy;
        logic [AW-1:0] e_addr;
        logic [2:0] e_idx;
        t0 = cyc;
        for (int i = 0; i < 10; i++) man_valid[t0+offs[i]] = 1'b1;
        auto_mem = 1'b0;
        mem_data_valid = 1'b0;
        dcache_addr = 16'h2468;
        dcache_miss = 1'b1;
        repeat (22) step();
        n = 0;
        for (int k = 0; k < 22; k++) begin
            e_en   = (k >= 1 && k <= 8);
            e_addr = e_en ? 16'h2460 + 16'(2*(k-1)) : 16'h0;
            e_dfw  = man_valid[t0+k] && (k <= 17);
            e_idx  = e_dfw ? 3'(n) : 3'd0;
            if (e_dfw) n++;
            e_dtw  = (k == 18);
            e_busy = (k >= 1 && k <= 18);
            checks++;
            if (obs(t0+k) !== {e_en, e_addr, 1'b0, e_dfw, e_idx, 1'b0, e_dtw, e_busy})
                begin errors++; $display("FAIL irregular cyc %0d: got %h required %h (en,addr,ifw,dfw,idx,itw,dtw,busy)",
                    k, obs(t0+k), {e_en, e_addr, 1'b0, e_dfw, e_idx, 1'b0, e_dtw, e_busy}); end
        end
        for (int i = 0; i < 10; i++) man_valid[t0+offs[i]] = 1'b0;
        auto_mem = 1'b1;
        mem_data_valid = 1'b0;
        repeat (LAT) step();
    endtask

    task automatic test_addr_hold_wrap();
        int t0;
        logic e_en, e_ifw, e_itw, e_busy;
        logic [AW-1:0] e_addr;
        logic [2:0] e_idx;
        t0 = cyc;
        icache_addr = 16'hFFF7;
        icache_miss = 1'b1;
        repeat (3) step();
        icache_addr = 16'h1234;
        repeat (13) step();
        for (int k = 0; k < 16; k++) begin
            e_en   = (k >= 1 && k <= 8);
            e_addr = e_en ? 16'hFFF0 + 16'(2*(k-1)) : 16'h0;
            e_ifw  = (k >= 5 && k <= 12);
            e_idx  = e_ifw ? 3'(k-5) : 3'd0;
            e_itw  = (k == 13);
            e_busy = (k >= 1 && k <= 13);
            checks++;
            if (obs(t0+k) !== {e_en, e_addr, e_ifw, 1'b0, e_idx, e_itw, 1'b0, e_busy})
                begin errors++; $display("FAIL addr_hold_wrap cyc %0d: got %h required %h (en,addr,ifw,dfw,idx,itw,dtw,busy)",
                    k, obs(t0+k), {e_en, e_addr, e_ifw, 1'b0, e_idx, e_itw, 1'b0, e_busy}); end
        end
    endtask

    task automatic test_reset_mid_fill();
        int t0, t1;
        logic e_en, e_dfw, e_dtw, e_busy;
        logic [AW-1:0] e_addr;
        logic [2:0] e_idx;
        t0 = cyc;
        dcache_addr = 16'h1236;
        dcache_miss = 1'b1;
        repeat (9) step();
        checks++;
        if (log_dfw[t0+8] !== 1'b1 || log_idx[t0+8] !== 3'd3)
            begin errors++; $display("FAIL rst_pre_idx: got dfw=%b idx=%0d required dfw=1 idx=3",
                log_dfw[t0+8], log_idx[t0+8]); end
        rst_n = 1'b0;
        dcache_miss = 1'b0;
        #1;
        checks++;
        if ({mem_en, mem_addr, fill_word_idx, icache_fill_we, dcache_fill_we,
             icache_tag_we, dcache_tag_we, busy} !== 25'h0)
            begin errors++; $display("FAIL rst_async_outputs: got %h required 0",
                {mem_en, mem_addr, fill_word_idx, icache_fill_we, dcache_fill_we,
                 icache_tag_we, dcache_tag_we, busy}); end
        step();
        rst_n = 1'b1;
        repeat (3) step();
        for (int k = 9; k <= 12; k++) begin
            checks++;
            if (obs(t0+k) !== 25'h0)
                begin errors++; $display("FAIL rst_stale_valid cyc %0d: got %h required 0", k, obs(t0+k)); end
        end
        t1 = cyc;
        dcache_miss = 1'b1;
        repeat (16) step();
        for (int k = 0; k < 16; k++) begin
            e_en   = (k >= 1 && k <= 8);
            e_addr = e_en ? 16'h1230 + 16'(2*(k-1)) : 16'h0;
            e_dfw  = (k >= 5 && k <= 12);
            e_idx  = e_dfw ? 3'(k-5) : 3'd0;
            e_dtw  = (k == 13);
            e_busy = (k >= 1 && k <= 13);
            checks++;
            if (obs(t1+k) !== {e_en, e_addr, 1'b0, e_dfw, e_idx, 1'b0, e_dtw, e_busy})
                begin errors++; $display("FAIL rst_refill cyc %0d: got %h required %h (en,addr,ifw,dfw,idx,itw,dtw,busy)",
                    k, obs(t1+k), {e_en, e_addr, 1'b0, e_dfw, e_idx, 1'b0, e_dtw, e_busy}); end
        end
    endtask

    task automatic test_starve();
        int t0;
        logic          e2_ifw, e2_dfw, e3_ifw, e3_dfw;
        logic [AW-1:0] e2_addr, e3_addr;
`ifdef FILL_STARVE_GUARD_EN
        e2_ifw = 1'b1; e2_dfw = 1'b0; e2_addr = 16'h0100;
        e3_ifw = 1'b0; e3_dfw = 1'b1; e3_addr = 16'h0300;
`else
        e2_ifw = 1'b0; e2_dfw = 1'b1; e2_addr = 16'h0300;
        e3_ifw = 1'b1; e3_dfw = 1'b0; e3_addr = 16'h0100;
`endif
        t0 = cyc;
        icache_addr = 16'h0104;
        dcache_addr = 16'h0208;
        icache_miss = 1'b1;
        dcache_miss = 1'b1;
        repeat (14) step();
        dcache_addr = 16'h030A;
        dcache_miss = 1'b1;
        repeat (30) step();
        checks++;
        if ({log_en[t0+1], log_addr[t0+1], log_ifw[t0+5], log_dfw[t0+5]} !== {1'b1, 16'h0200, 1'b0, 1'b1})
            begin errors++; $display("FAIL starve_fill1: got en=%b addr=%h ifw=%b dfw=%b required en=1 addr=0200 ifw=0 dfw=1",
                log_en[t0+1], log_addr[t0+1], log_ifw[t0+5], log_dfw[t0+5]); end
        checks++;
        if ({log_en[t0+15], log_addr[t0+15], log_ifw[t0+19], log_dfw[t0+19]} !== {1'b1, e2_addr, e2_ifw, e2_dfw})
            begin errors++; $display("FAIL starve_fill2: got en=%b addr=%h ifw=%b dfw=%b required en=1 addr=%h ifw=%b dfw=%b",
                log_en[t0+15], log_addr[t0+15], log_ifw[t0+19], log_dfw[t0+19], e2_addr, e2_ifw, e2_dfw); end
        checks++;
        if ({log_en[t0+29], log_addr[t0+29], log_ifw[t0+33], log_dfw[t0+33]} !== {1'b1, e3_addr, e3_ifw, e3_dfw})
            begin errors++; $display("FAIL starve_fill3: got en=%b addr=%h ifw=%b dfw=%b required en=1 addr=%h ifw=%b dfw=%b",
                log_en[t0+29], log_addr[t0+29], log_ifw[t0+33], log_dfw[t0+33], e3_addr, e3_ifw, e3_dfw); end
        checks++;
        if ({log_itw[t0+41] | log_dtw[t0+41], log_busy[t0+42], icache_miss, dcache_miss} !== 4'b1000)
            begin errors++; $display("FAIL starve_end: got tag=%b busy=%b imiss=%b dmiss=%b required 1 0 0 0",
                log_itw[t0+41] | log_dtw[t0+41], log_busy[t0+42], icache_miss, dcache_miss); end
    endtask

    initial begin
        for (int i = 0; i < NLOG; i++) man_valid[i] = 1'b0;
        test_reset();
        test_single_d();
        test_simultaneous();
        test_irregular();
        test_addr_hold_wrap();
        test_reset_mid_fill();
        test_starve();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete within 100000 time units");
        $fatal(1);
    end

endmodule
